// File: rtl/gps_spi_framer.sv
// rtl/gps_spi_framer.sv - packs NCH-bit GPS samples into MCU_SS-framed SPI bursts
// Optional frame sequence header enabled by macro GPS_SPI_FRAMER_SEQ_EN.
module gps_spi_framer #(
  parameter int NCH     = 4,
  parameter int SPF     = 8,
  parameter int MIN_GAP = 2
) (
  input  logic           MCU_CLK_25_000,
  input  logic           RESET_N,
  input  logic           DATAREADY,
  input  logic [NCH-1:0] GPS_DATA,
  output logic           MCU_SCK,
  output logic           MCU_SS,
  output logic           MCU_MOSI,
  output logic           BUSY,
  output logic           OVERRUN
);

`ifdef GPS_SPI_FRAMER_SEQ_EN
  localparam int HDR = 8;
`else
  localparam int HDR = 0;
`endif
  localparam int SW = NCH + HDR;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_WAIT, S_GAP} state_t;

  state_t        state, state_nx;
  logic [SW-1:0] shreg, shreg_nx;
  logic [4:0]    bit_cnt, bit_cnt_nx;
  logic [7:0]    samp_cnt, samp_cnt_nx;
  logic [3:0]    gap_cnt, gap_cnt_nx;
  logic          ss, ss_nx;
  logic          sck_en, sck_en_nx;
  logic          ovr, ovr_nx;
  logic          last_bit;
  logic          more;
  logic          accept;
`ifdef GPS_SPI_FRAMER_SEQ_EN
  logic [7:0]    seq, seq_nx;
`endif

  assign last_bit = (bit_cnt == 5'd0);
  assign more     = (samp_cnt < 8'(SPF - 1));
  assign accept   = DATAREADY && ((state == S_IDLE) || (state == S_WAIT) ||
                                  ((state == S_SHIFT) && last_bit && more));

  always_comb begin
    state_nx    = state;
    shreg_nx    = shreg;
    bit_cnt_nx  = bit_cnt;
    samp_cnt_nx = samp_cnt;
    gap_cnt_nx  = gap_cnt;
    ss_nx       = ss;
    sck_en_nx   = sck_en;
    ovr_nx      = ovr | (DATAREADY & ~accept);
`ifdef GPS_SPI_FRAMER_SEQ_EN
    seq_nx      = seq;
`endif
    case (state)
      S_IDLE: begin
        ss_nx     = 1'b1;
        sck_en_nx = 1'b0;
        if (accept) begin
          state_nx   = S_SHIFT;
          ss_nx      = 1'b0;
          sck_en_nx  = 1'b1;
          bit_cnt_nx = 5'(SW - 1);
`ifdef GPS_SPI_FRAMER_SEQ_EN
          shreg_nx   = {GPS_DATA, seq};
`else
          shreg_nx   = SW'(GPS_DATA);
`endif
        end
      end
      S_SHIFT: begin
        if (!last_bit) begin
          shreg_nx   = shreg >> 1;
          bit_cnt_nx = bit_cnt - 5'd1;
        end else if (accept) begin
          // back-to-back sample: reload without dropping SCK
          shreg_nx    = SW'(GPS_DATA);
          bit_cnt_nx  = 5'(NCH - 1);
          samp_cnt_nx = samp_cnt + 8'd1;
        end else begin
          sck_en_nx   = 1'b0;
          samp_cnt_nx = samp_cnt + 8'd1;
          if (({1'b0, samp_cnt} + 9'd1) < 9'(SPF)) begin
            state_nx = S_WAIT;
          end else begin
            state_nx   = S_GAP;
            ss_nx      = 1'b1;
            gap_cnt_nx = 4'(MIN_GAP - 1);
`ifdef GPS_SPI_FRAMER_SEQ_EN
            seq_nx     = seq + 8'd1;
`endif
          end
        end
      end
      S_WAIT: begin
        if (accept) begin
          state_nx   = S_SHIFT;
          sck_en_nx  = 1'b1;
          shreg_nx   = SW'(GPS_DATA);
          bit_cnt_nx = 5'(NCH - 1);
        end
      end
      S_GAP: begin
        if (gap_cnt == 4'd0) begin
          state_nx    = S_IDLE;
          samp_cnt_nx = 8'd0;
        end else begin
          gap_cnt_nx = gap_cnt - 4'd1;
        end
      end
      default: begin
        state_nx  = S_IDLE;
        ss_nx     = 1'b1;
        sck_en_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) begin
      state    <= S_IDLE;
      shreg    <= '0;
      bit_cnt  <= 5'd0;
      samp_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
      ss       <= 1'b1;
      sck_en   <= 1'b0;
      ovr      <= 1'b0;
    end else begin
      state    <= state_nx;
      shreg    <= shreg_nx;
      bit_cnt  <= bit_cnt_nx;
      samp_cnt <= samp_cnt_nx;
      gap_cnt  <= gap_cnt_nx;
      ss       <= ss_nx;
      sck_en   <= sck_en_nx;
      ovr      <= ovr_nx;
    end
  end

`ifdef GPS_SPI_FRAMER_SEQ_EN
  always_ff @(posedge MCU_CLK_25_000) begin
    if (!RESET_N) seq <= 8'd0;
    else          seq <= seq_nx;
  end
`endif

  // MOSI comes straight from the shift register flop, never from GPS_DATA
  assign MCU_MOSI = shreg[0];
  assign MCU_SCK  = MCU_CLK_25_000 & sck_en;
  assign MCU_SS   = ss;
  assign BUSY     = (state != S_IDLE);
  assign OVERRUN  = ovr;

endmodule

// File: tb/tb_gps_spi_framer.sv
// tb/tb_gps_spi_framer.sv - directed bench for gps_spi_framer
module tb_gps_spi_framer;
  localparam int NCH = 4;
`ifdef GPS_SPI_FRAMER_SEQ_EN
  localparam int SPF = 1;
`else
  localparam int SPF = 8;
`endif

  logic       MCU_CLK_25_000 = 1'b0;
  logic       RESET_N = 1'b0;
  logic       DATAREADY = 1'b0;
  logic [3:0] GPS_DATA = 4'd0;
  logic       MCU_SCK, MCU_SS, MCU_MOSI, BUSY, OVERRUN;

  int   total = 0;
  int   bad = 0;
  int   sck_cnt = 0;
  logic bitq[$];

  gps_spi_framer #(.NCH(NCH), .SPF(SPF), .MIN_GAP(2)) dut (
    .MCU_CLK_25_000 (MCU_CLK_25_000),
    .RESET_N        (RESET_N),
    .DATAREADY      (DATAREADY),
    .GPS_DATA       (GPS_DATA),
    .MCU_SCK        (MCU_SCK),
    .MCU_SS         (MCU_SS),
    .MCU_MOSI       (MCU_MOSI),
    .BUSY           (BUSY),
    .OVERRUN        (OVERRUN)
  );

  always #5 MCU_CLK_25_000 = ~MCU_CLK_25_000;

  // while the clock is high, MCU_SCK equals the registered enable
  always @(posedge MCU_CLK_25_000) begin
    #1;
    if (MCU_SCK === 1'b1) begin
      sck_cnt = sck_cnt + 1;
      bitq.push_back(MCU_MOSI);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge MCU_CLK_25_000);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    DATAREADY = 1'b0;
    tick();
    tick();
    RESET_N = 1'b1;
    sck_cnt = 0;
    bitq.delete();
  endtask

  function automatic logic [31:0] packq();
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < bitq.size() && i < 32; i++) v[i] = bitq[i];
    return v;
  endfunction

`ifdef GPS_SPI_FRAMER_SEQ_EN
  initial begin
    logic [3:0]  dv;
    logic [11:0] ev;
    do_reset();
    for (int f = 0; f < 257; f++) begin
      sck_cnt = 0;
      bitq.delete();
      dv = 4'(f * 5 + 3);
      ev = {dv, 8'(f)};
      DATAREADY = 1'b1;
      GPS_DATA = dv;
      tick();
      DATAREADY = 1'b0;
      check("seq_ss_first", 32'(MCU_SS), 32'd0);
      repeat (11) tick();
      check("seq_ss_last", 32'(MCU_SS), 32'd0);
      tick();
      check("seq_ss_gap", 32'(MCU_SS), 32'd1);
      check("seq_nbits", 32'(bitq.size()), 32'd12);
      check("seq_frame", packq(), 32'(ev));
      repeat (2) tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`else
  initial begin
    logic [3:0]  p;
    logic [3:0]  d2 [8];
    logic [3:0]  d3 [8];
    logic [31:0] ev;

    d2 = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF, 4'h0, 4'hA, 4'h5};
    d3 = '{4'h3, 4'hC, 4'h6, 4'h9, 4'h7, 4'hE, 4'hB, 4'hD};

    // reset state, single sample
    do_reset();
    check("rst_ss", 32'(MCU_SS), 32'd1);
    check("rst_sck", 32'(MCU_SCK), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_ovr", 32'(OVERRUN), 32'd0);
    check("rst_mosi", 32'(MCU_MOSI), 32'd0);
    p = 4'b0110;
    DATAREADY = 1'b1;
    GPS_DATA = p;
    tick();
    DATAREADY = 1'b0;
    check("t1_ss", 32'(MCU_SS), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t1_sck", 32'(MCU_SCK), 32'd1);
      check("t1_mosi", 32'(MCU_MOSI), 32'(p[i]));
      tick();
    end
    check("t1_sck_off", 32'(MCU_SCK), 32'd0);
    check("t1_wait_ss", 32'(MCU_SS), 32'd0);
    check("t1_wait_busy", 32'(BUSY), 32'd1);
    repeat (3) tick();
    check("t1_wait_ss2", 32'(MCU_SS), 32'd0);
    check("t1_pulses", 32'(sck_cnt), 32'd4);

    // full frame, strobes 8 cycles apart
    do_reset();
    for (int k = 0; k < 8; k++) begin
      DATAREADY = 1'b1;
      GPS_DATA = d2[k];
      tick();
      DATAREADY = 1'b0;
      if (k < 7) begin
        repeat (7) tick();
        check("t2_ss_wait", 32'(MCU_SS), 32'd0);
      end
    end
    repeat (4) tick();
    check("t2_gap1_ss", 32'(MCU_SS), 32'd1);
    check("t2_gap1_busy", 32'(BUSY), 32'd1);
    tick();
    check("t2_gap2_ss", 32'(MCU_SS), 32'd1);
    check("t2_gap2_busy", 32'(BUSY), 32'd1);
    tick();
    check("t2_idle_busy", 32'(BUSY), 32'd0);
    check("t2_idle_ss", 32'(MCU_SS), 32'd1);
    check("t2_pulses", 32'(sck_cnt), 32'd32);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) ev[k*4+j] = d2[k][j];
    check("t2_bits", packq(), ev);

    // back-to-back strobes every 4 cycles
    do_reset();
    for (int k = 0; k < 8; k++) begin
      DATAREADY = 1'b1;
      GPS_DATA = d3[k];
      tick();
      DATAREADY = 1'b0;
      check("t3_sck", 32'(MCU_SCK), 32'd1);
      repeat (3) begin
        tick();
        check("t3_sck", 32'(MCU_SCK), 32'd1);
      end
    end
    tick();
    check("t3_ss_end", 32'(MCU_SS), 32'd1);
    check("t3_ovr", 32'(OVERRUN), 32'd0);
    check("t3_pulses", 32'(sck_cnt), 32'd32);
    for (int k = 0; k < 8; k++)
      for (int j = 0; j < 4; j++) ev[k*4+j] = d3[k][j];
    check("t3_bits", packq(), ev);

    // strobe during the second shift cycle is dropped
    do_reset();
    DATAREADY = 1'b1;
    GPS_DATA = 4'b0110;
    tick();
    DATAREADY = 1'b0;
    GPS_DATA = 4'b1001;
    tick();
    DATAREADY = 1'b1;
    tick();
    DATAREADY = 1'b0;
    check("t4_ovr", 32'(OVERRUN), 32'd1);
    check("t4_mosi_b2", 32'(MCU_MOSI), 32'd1);
    repeat (2) tick();
    check("t4_pulses", 32'(sck_cnt), 32'd4);
    check("t4_bits", packq(), 32'h6);
    check("t4_ovr_hold", 32'(OVERRUN), 32'd1);
    check("t4_ss_wait", 32'(MCU_SS), 32'd0);

    // reset on shift bit 2 from a WAIT-resumed sample, with a strobe at the same edge
    sck_cnt = 0;
    bitq.delete();
    DATAREADY = 1'b1;
    GPS_DATA = 4'b1111;
    tick();
    DATAREADY = 1'b0;
    repeat (2) tick();
    check("t5_mosi_b2", 32'(MCU_MOSI), 32'd1);
    RESET_N = 1'b0;
    DATAREADY = 1'b1;
    tick();
    RESET_N = 1'b1;
    DATAREADY = 1'b0;
    check("t5_ss", 32'(MCU_SS), 32'd1);
    check("t5_sck", 32'(MCU_SCK), 32'd0);
    check("t5_busy", 32'(BUSY), 32'd0);
    check("t5_ovr", 32'(OVERRUN), 32'd0);
    check("t5_mosi", 32'(MCU_MOSI), 32'd0);
    repeat (4) tick();
    check("t5_pulses", 32'(sck_cnt), 32'd3);
    check("t5_busy2", 32'(BUSY), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
`endif

endmodule

// File: doc/gps_spi_framer.md
GPS_SPI_FRAMER -- requirements
Module: gps_spi_framer

Interface
REQ-001 Parameter NCH, default 4, number of 1-bit GPS sample channels per sample (legal 1..8).
REQ-002 Parameter SPF, default 8, samples per SPI frame, i.e. per MCU_SS low period (legal 1..255).
REQ-003 Parameter MIN_GAP, default 2, minimum MCU_SS high cycles between frames (legal 1..15).
REQ-004 MCU_CLK_25_000  input  1  sole clock; all state updates on rising edge.
REQ-005 RESET_N  input  1  reset, synchronous, active-low.
REQ-006 DATAREADY  input  1  sample strobe; one sample accepted per cycle in which it is sampled high.
REQ-007 GPS_DATA  input  NCH  channel bits; bit 0 = I0, bit 1 = I1, bit 2 = Q0, bit 3 = Q1, higher bits = extra channels.
REQ-008 MCU_SCK  output  1  gated clock: MCU_CLK_25_000 AND registered enable.
REQ-009 MCU_SS  output  1  active-low frame select, registered.
REQ-010 MCU_MOSI  output  1  serial data, registered; MCU samples on MCU_SCK falling edge.
REQ-011 BUSY  output  1  high whenever state is not IDLE.
REQ-012 OVERRUN  output  1  sticky; a DATAREADY was dropped.

Function
REQ-013 States: IDLE, SHIFT, WAIT, GAP.
REQ-014 Accept = DATAREADY high AND (state IDLE, or WAIT, or SHIFT on last bit with samples-sent < SPF-1).
REQ-015 On the accept edge, GPS_DATA is latched into an NCH-bit shift register; no combinational path from GPS_DATA to MCU_MOSI.
REQ-016 IDLE accept: MCU_SS low, SCK enable high, state SHIFT, all from the next cycle; first MCU_SCK pulse in the cycle after the accept edge.
REQ-017 SHIFT: one bit per cycle, bit 0 first, NCH cycles per sample; MCU_MOSI stable for the whole cycle.
REQ-018 Last SHIFT bit without accept: SCK enable low; samples-sent increments; state WAIT if samples-sent < SPF, else GAP with MCU_SS high.
REQ-019 Last SHIFT bit with accept: shifting continues seamlessly, no idle SCK cycle.
REQ-020 WAIT: MCU_SS held low, MCU_SCK low; accept returns to SHIFT as in REQ-016.
REQ-021 GAP: MCU_SS high for exactly MIN_GAP cycles, then IDLE; samples-sent cleared.
REQ-022 DATAREADY high when not accepted: sample dropped, OVERRUN set from next cycle; state machine unaffected.
REQ-023 SPF=1: every sample ends its frame; REQ-019 never applies.
REQ-024 Unreachable state encodings return to IDLE in one cycle.

Reset
REQ-025 RESET_N low at an edge: state IDLE, MCU_SS=1, SCK enable=0, MCU_MOSI=0, BUSY=0, OVERRUN=0, counters 0, from the next cycle.
REQ-026 Reset mid-frame aborts immediately; no further MCU_SCK pulses; a DATAREADY in the same cycle is ignored.

Configuration
REQ-027 Macro GPS_SPI_FRAMER_SEQ_EN defined: each frame begins with an 8-bit sequence number, bit 0 first, shifted before sample 0 within the same MCU_SS low period; sequence increments per completed frame, wraps 255->0, resets to 0.
REQ-028 Macro defined: the first accept of a frame produces 8+NCH contiguous SCK cycles.
REQ-029 Macro undefined: no header; frame is SPF*NCH bits; no sequence register.

Verification
REQ-030 Reset, single DATAREADY with GPS_DATA=4'b0110, SPF=8 -> SS low next cycle, 4 SCK pulses, MOSI 0,1,1,0, SS stays low, state WAIT.
REQ-031 8 DATAREADY strobes, 8 cycles apart -> 32 SCK pulses, SS high after last bit for exactly 2 cycles, then BUSY low.
REQ-032 DATAREADY every 4 cycles, first on an IDLE cycle -> back-to-back shifting, no gap in SCK within a frame, OVERRUN stays 0.
REQ-033 DATAREADY on second SHIFT cycle -> sample dropped, OVERRUN=1 until reset, current sample bits unchanged.
REQ-034 RESET_N low on SHIFT bit 2 -> next cycle SS=1, no SCK, BUSY=0, OVERRUN=0.
REQ-035 SEQ_EN defined, 257 frames of SPF=1 -> headers 0..255 then 0, each followed by 4 sample bits under one SS low period.
